alu_lock_arbiter: RTL
=====================

// Module: alu_lock_arbiter
// PURPOSE
// - Owns the single shared ALU lock for all SIC exec units.
// - Collects per-SIC lock requests tagged with issue IDs and grants the oldest in-flight instruction.
// - Holds the grant until the owner pulses release_lock, then hands over back-to-back.
// - Sits between the SIC array and the shared ALU. Its grant vector drives each SIC's alu_grant and the ALU operand mux select.
// PARAMETERS
// - NUM_SICS     4    number of requesting SIC exec units (>=2)
// - ID_WIDTH     8    issue-ID width; IDs wrap modulo 2^ID_WIDTH
// - TIMEOUT_CYC  64   watchdog limit in cycles; used only with ALU_LOCK_TIMEOUT_EN
// PORTS
// - clk            in   1                   clock, rising edge
// - rst_n          in   1                   asynchronous reset, active low
// - req            in   NUM_SICS            per-SIC lock request (level)
// - req_issue_id   in   NUM_SICS*ID_WIDTH   per-SIC issue ID; valid when req=1
// - release_lock   in   NUM_SICS            per-SIC one-cycle release pulse
// - grant          out  NUM_SICS            one-hot-or-zero grant (registered)
// - lock_busy      out  1                   lock currently held
// - owner_idx      out  $clog2(NUM_SICS)    index of current owner; 0 when idle
// - err_spurious   out  1                   sticky: release from a non-owner, or while idle
// - err_timeout    out  1                   sticky watchdog flag; tied 0 without the macro
// BEHAVIOUR
// - Reset: grant=0, lock_busy=0, owner_idx=0, err_*=0, FSM=IDLE, watchdog count=0.
// - FSM IDLE:
//   - If any req=1 at edge t, select the winner, set grant[win]=1 and go to HELD.
//   - Visible at t+1, so request-to-grant latency is 1 cycle.
// - FSM HELD:
//   - release_lock[owner]=1 at edge t: drop grant at t+1.
//   - In the same cycle, re-arbitrate among req excluding the owner.
//   - If any candidate exists, grant it at t+1 and stay in HELD, with no idle bubble. Otherwise go to IDLE.
// - Winner selection:
//   - Pick the oldest ID by wrap-around compare: a older than b iff MSB of (a-b) mod 2^ID_WIDTH is 1.
//   - If IDs are equal, the lowest index wins.
// - Owner req drop without release: the grant is kept. Owner abort always issues a release pulse.
// - Non-owner release, or release while IDLE: ignored and sets err_spurious.
// - A non-owner request appearing while HELD: waits. It is never pre-empted, even if older.
// - Simultaneous owner release plus a new older request: the new request is eligible in the same cycle.
// - Reset mid-grant: grant drops asynchronously. A SIC that committed keeps its pending release pulse, which is then flagged spurious.
// - grant is never multi-hot. Assert $onehot0(grant) each cycle.
// CONFIGURATION
// - ALU_LOCK_TIMEOUT_EN defined:
//   - A counter increments each HELD cycle and clears on handover.
//   - At count==TIMEOUT_CYC-1 the lock is force-revoked the next cycle (grant=0, FSM to IDLE or next winner) and err_timeout sets (sticky).
// - ALU_LOCK_TIMEOUT_EN undefined: no counter, err_timeout=0, and the lock is held indefinitely.
// STRUCTURE
// - structs.svh: alu_lock_req#(ID_WIDTH)::t {req, issue_id}, plus function id_older(a,b) shared with the issue logic.
// - Sub-module alu_age_select (combinational): oldest-first reduction tree over NUM_SICS candidates with a mask input.
//   - Outputs found and win_idx.
//   - Instantiated once, with mask = req & ~(HELD ? grant : 0).
// - Top level: FSM, owner register, error flags, and the optional watchdog.
// TESTING
// - Single request:
//   - req[2]=1, id=5 at t0 -> grant=4'b0100 at t0+1, lock_busy=1, owner_idx=2.
//   - release_lock[2] -> grant=0 next cycle.
// - Oldest first:
//   - req[0] id=9, req[1] id=7, req[3] id=8 together -> grant[1].
//   - Release -> grant[3] the following cycle. Release -> grant[0].
// - Wrap-around:
//   - ID_WIDTH=8, req[0] id=250, req[1] id=3 -> grant[0] (250 older).
// - Back-to-back handover:
//   - Owner 1 releases at t while req[2]=1 -> grant=4'b0100 at t+1 with no idle cycle.
// - Spurious release:
//   - release_lock[3] while owner=0 -> grant unchanged, err_spurious=1 and it stays set.
// - Timeout (macro on, TIMEOUT_CYC=16):
//   - Owner never releases -> grant drops after 16 HELD cycles, err_timeout=1, pending req[1] granted.

Source files
------------

// File: rtl/alu_lock_arbiter_pkg.sv
// Shared types and helpers for the ALU lock arbiter and the issue logic.
// Issue-ID age compare wraps modulo 2^width.
package alu_lock_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } lock_state_e;

    // Index width that stays legal for a single-entry vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // a is older than b when bit (width-1) of (a - b) is set; ids zero-extended to 32 bits.
    function automatic logic id_older(input logic [31:0] a, input logic [31:0] b,
                                      input int unsigned width);
        return |((a - b) & (32'd1 << (width - 1)));
    endfunction

endpackage

// File: rtl/alu_lock_arbiter_age_select.sv
// Combinational oldest-issue-ID selector over the masked request vector.
// Equal IDs resolve to the lowest index.
module alu_age_select
    import alu_lock_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_SICS = 4,
    parameter  int unsigned ID_WIDTH = 8,
    localparam int unsigned IDX_W    = idx_width(NUM_SICS)
) (
    input  logic [NUM_SICS-1:0]          req_i,
    input  logic [NUM_SICS-1:0]          mask_i,
    input  logic [NUM_SICS*ID_WIDTH-1:0] id_i,
    output logic                         found_c_o,
    output logic [IDX_W-1:0]             win_idx_c_o
);

    logic [ID_WIDTH-1:0] best_id;
    logic [ID_WIDTH-1:0] cand_id;

    // Running oldest: a later entry only replaces the holder when strictly older.
    always_comb begin
        found_c_o   = 1'b0;
        win_idx_c_o = '0;
        best_id     = '0;
        cand_id     = '0;
        for (int unsigned i = 0; i < NUM_SICS; i++) begin
            cand_id = id_i[i*ID_WIDTH +: ID_WIDTH];
            if (req_i[i] && mask_i[i] &&
                (!found_c_o || id_older(32'(cand_id), 32'(best_id), ID_WIDTH))) begin
                found_c_o   = 1'b1;
                win_idx_c_o = IDX_W'(i);
                best_id     = cand_id;
            end
        end
    end

endmodule

// File: rtl/alu_lock_arbiter.sv
// Single shared ALU lock: grants the oldest requesting SIC and hands over on release.
// Optional watchdog revoke is enabled by defining ALU_LOCK_TIMEOUT_EN.
module alu_lock_arbiter
    import alu_lock_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_SICS    = 4,
    parameter  int unsigned ID_WIDTH    = 8,
    parameter  int unsigned TIMEOUT_CYC = 64,
    localparam int unsigned IDX_W       = idx_width(NUM_SICS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SICS-1:0]          req,
    input  logic [NUM_SICS*ID_WIDTH-1:0] req_issue_id,
    input  logic [NUM_SICS-1:0]          release_lock,
    output logic [NUM_SICS-1:0]          grant,
    output logic                         lock_busy,
    output logic [IDX_W-1:0]             owner_idx,
    output logic                         err_spurious,
    output logic                         err_timeout
);

    lock_state_e         state_q, state_d;
    logic [NUM_SICS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                err_sp_q, err_sp_d;
    logic                err_to_q, err_to_d;

    logic [NUM_SICS-1:0] held_mask_c;
    logic                found_c;
    logic [IDX_W-1:0]    win_idx_c;
    logic                owner_rel_c;
    logic                spurious_c;
    logic                timeout_hit_c;
    logic                handover_c;

    // The current owner is excluded so a handover never re-grants the releasing SIC.
    assign held_mask_c = (state_q == ST_HELD) ? grant_q : '0;
    assign owner_rel_c = |(release_lock & held_mask_c);
    assign spurious_c  = |(release_lock & ~held_mask_c);
    assign handover_c  = owner_rel_c | timeout_hit_c;

    alu_age_select #(
        .NUM_SICS (NUM_SICS),
        .ID_WIDTH (ID_WIDTH)
    ) u_age_select (
        .req_i       (req),
        .mask_i      (~held_mask_c),
        .id_i        (req_issue_id),
        .found_c_o   (found_c),
        .win_idx_c_o (win_idx_c)
    );

`ifdef ALU_LOCK_TIMEOUT_EN
    localparam int unsigned WD_W = idx_width(TIMEOUT_CYC);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    assign timeout_hit_c = (state_q == ST_HELD) && (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));

    // Counts cycles of the current tenure; any handover or idle restarts it.
    always_comb begin
        wd_cnt_d = '0;
        if ((state_q == ST_HELD) && !handover_c) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign timeout_hit_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (found_c) state_d = ST_HELD;
            ST_HELD: if (handover_c && !found_c) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Re-arbitrate whenever idle or the lock is being handed over.
    always_comb begin
        grant_d  = grant_q;
        owner_d  = owner_q;
        err_sp_d = err_sp_q | spurious_c;
        err_to_d = err_to_q | timeout_hit_c;
        if ((state_q == ST_IDLE) || handover_c) begin
            if (found_c) begin
                grant_d = NUM_SICS'(1) << win_idx_c;
                owner_d = win_idx_c;
            end else begin
                grant_d = '0;
                owner_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q  <= '0;
            owner_q  <= '0;
            err_sp_q <= 1'b0;
            err_to_q <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            err_sp_q <= err_sp_d;
            err_to_q <= err_to_d;
        end
    end

    assign grant        = grant_q;
    assign lock_busy    = (state_q == ST_HELD);
    assign owner_idx    = owner_q;
    assign err_spurious = err_sp_q;
    assign err_timeout  = err_to_q;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));

endmodule
